// File: rtl/mipi_img_window.sv
// Crops a rectangular window out of a deserialized MIPI pixel stream and measures
// the incoming line/frame geometry. Everything runs in the img_clk domain.
module mipi_img_window #(
    parameter int DATA_WIDTH = 10,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                  img_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] dati,
    input  logic                  dvi,
    input  logic                  lvi,
    input  logic                  fvi,
    input  logic [DIM_WIDTH-1:0]  col_start,
    input  logic [DIM_WIDTH-1:0]  num_cols,
    input  logic [DIM_WIDTH-1:0]  row_start,
    input  logic [DIM_WIDTH-1:0]  num_rows,
    output logic [DATA_WIDTH-1:0] dato,
    output logic                  dvo,
    output logic                  lvo,
    output logic                  fvo,
    output logic [DIM_WIDTH-1:0]  meas_cols,
    output logic [DIM_WIDTH-1:0]  meas_rows,
    output logic [DIM_WIDTH-1:0]  frame_count
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FRAME    = 2'd2
    } state_t;

    localparam logic [DIM_WIDTH-1:0] DIM_MAX = '1;

    state_t state_q, state_d;

    logic                  fvi_q, lvi_q;
    logic                  en_q, en_d;
    logic [DIM_WIDTH-1:0]  col_start_q, col_start_d;
    logic [DIM_WIDTH-1:0]  num_cols_q, num_cols_d;
    logic [DIM_WIDTH-1:0]  row_start_q, row_start_d;
    logic [DIM_WIDTH-1:0]  num_rows_q, num_rows_d;
    logic [DIM_WIDTH-1:0]  col_cnt_q, col_cnt_d;
    logic [DIM_WIDTH-1:0]  row_cnt_q, row_cnt_d;
    logic [DATA_WIDTH-1:0] dato_q, dato_d;
    logic                  dvo_q, dvo_d;
    logic                  lvo_q, lvo_d;
    logic                  fvo_q, fvo_d;
    logic [DIM_WIDTH-1:0]  meas_cols_q, meas_cols_d;
    logic [DIM_WIDTH-1:0]  meas_rows_q, meas_rows_d;
    logic [DIM_WIDTH-1:0]  frame_count_q, frame_count_d;

    logic frame_start, frame_end;
    logic in_frame, latch_win, frame_done;
    logic line_start, line_end, frame_act, pix_ok;
    logic row_hit, col_hit, win_ok;
    logic [DIM_WIDTH-1:0] col_cur, row_after_line;

    assign frame_start = fvi & ~fvi_q;
    assign frame_end   = ~fvi & fvi_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge img_clk) begin
        if (reset) begin
            state_q <= ST_DISARMED;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DISARMED: if (!fvi)        state_d = ST_ARMED;
            ST_ARMED:    if (frame_start) state_d = ST_FRAME;
            ST_FRAME:    if (frame_end)   state_d = ST_ARMED;
            default:                      state_d = ST_DISARMED;
        endcase
    end

    // ---------------- FSM: decoded outputs ----------------
    always_comb begin
        in_frame   = (state_q == ST_FRAME);
        latch_win  = (state_q == ST_ARMED) & frame_start;
        frame_done = in_frame & frame_end;
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        line_start = in_frame & lvi & ~lvi_q;
        line_end   = in_frame & ~lvi & lvi_q;
        // The frame-end cycle already counts as outside the frame for pixels and lvo.
        frame_act  = in_frame & fvi;
        pix_ok     = frame_act & lvi & dvi;

        en_d        = latch_win ? enable    : en_q;
        col_start_d = latch_win ? col_start : col_start_q;
        num_cols_d  = latch_win ? num_cols  : num_cols_q;
        row_start_d = latch_win ? row_start : row_start_q;
        num_rows_d  = latch_win ? num_rows  : num_rows_q;

        col_cur   = line_start ? '0 : col_cnt_q;
        col_cnt_d = col_cur;
        if (pix_ok && (col_cur != DIM_MAX)) begin
            col_cnt_d = col_cur + DIM_WIDTH'(1);
        end

        row_after_line = row_cnt_q;
        if (line_end && (row_cnt_q != DIM_MAX)) begin
            row_after_line = row_cnt_q + DIM_WIDTH'(1);
        end
        row_cnt_d = latch_win ? '0 : row_after_line;

        // Window bounds are evaluated one bit wider so start+size never wraps.
        row_hit = ({1'b0, row_cnt_q} >= {1'b0, row_start_q}) &&
                  ({1'b0, row_cnt_q} <  ({1'b0, row_start_q} + {1'b0, num_rows_q}));
        col_hit = ({1'b0, col_cur} >= {1'b0, col_start_q}) &&
                  ({1'b0, col_cur} <  ({1'b0, col_start_q} + {1'b0, num_cols_q}));
        win_ok  = en_q & (|num_cols_q) & (|num_rows_q);

        dvo_d  = pix_ok & row_hit & col_hit & win_ok;
        lvo_d  = frame_act & lvi & row_hit & win_ok;
        fvo_d  = fvi & (state_d == ST_FRAME) & en_d;
        dato_d = dvo_d ? dati : dato_q;

        meas_cols_d   = line_end   ? col_cnt_q      : meas_cols_q;
        meas_rows_d   = frame_done ? row_after_line : meas_rows_q;
        frame_count_d = frame_done ? frame_count_q + DIM_WIDTH'(1) : frame_count_q;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge img_clk) begin
        if (reset) begin
            fvi_q         <= 1'b0;
            lvi_q         <= 1'b0;
            en_q          <= 1'b0;
            col_start_q   <= '0;
            num_cols_q    <= '0;
            row_start_q   <= '0;
            num_rows_q    <= '0;
            col_cnt_q     <= '0;
            row_cnt_q     <= '0;
            dato_q        <= '0;
            dvo_q         <= 1'b0;
            lvo_q         <= 1'b0;
            fvo_q         <= 1'b0;
            meas_cols_q   <= '0;
            meas_rows_q   <= '0;
            frame_count_q <= '0;
        end else begin
            fvi_q         <= fvi;
            lvi_q         <= lvi;
            en_q          <= en_d;
            col_start_q   <= col_start_d;
            num_cols_q    <= num_cols_d;
            row_start_q   <= row_start_d;
            num_rows_q    <= num_rows_d;
            col_cnt_q     <= col_cnt_d;
            row_cnt_q     <= row_cnt_d;
            dato_q        <= dato_d;
            dvo_q         <= dvo_d;
            lvo_q         <= lvo_d;
            fvo_q         <= fvo_d;
            meas_cols_q   <= meas_cols_d;
            meas_rows_q   <= meas_rows_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign dato        = dato_q;
    assign dvo         = dvo_q;
    assign lvo         = lvo_q;
    assign fvo         = fvo_q;
    assign meas_cols   = meas_cols_q;
    assign meas_rows   = meas_rows_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_mipi_img_window.sv
// Directed bench for mipi_img_window, built with a 4-bit dimension width so the
// frame counter wrap and column saturation are reachable in a short run.
module tb_mipi_img_window;

    localparam int DW = 10;
    localparam int NW = 4;

    logic          img_clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] dati;
    logic          dvi, lvi, fvi;
    logic [NW-1:0] col_start, num_cols, row_start, num_rows;
    logic [DW-1:0] dato;
    logic          dvo, lvo, fvo;
    logic [NW-1:0] meas_cols, meas_rows, frame_count;

    mipi_img_window #(.DATA_WIDTH(DW), .DIM_WIDTH(NW)) dut (
        .img_clk     (img_clk),
        .reset       (reset),
        .enable      (enable),
        .dati        (dati),
        .dvi         (dvi),
        .lvi         (lvi),
        .fvi         (fvi),
        .col_start   (col_start),
        .num_cols    (num_cols),
        .row_start   (row_start),
        .num_rows    (num_rows),
        .dato        (dato),
        .dvo         (dvo),
        .lvo         (lvo),
        .fvo         (fvo),
        .meas_cols   (meas_cols),
        .meas_rows   (meas_rows),
        .frame_count (frame_count)
    );

    always #5 img_clk = ~img_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int dvo_tot = 0, lvo_tot = 0, fvo_tot = 0;
    int fvi_cnt = 0;
    int got[$];
    int exp_q[$];
    int cut_lvo_pre, cut_lvo_post, cut_dvo_post;

    // Output monitor on the falling edge, away from the active edge.
    always @(negedge img_clk) begin
        if (dvo) begin
            dvo_tot <= dvo_tot + 1;
            got.push_back(int'(dato));
        end
        if (lvo) lvo_tot <= lvo_tot + 1;
        if (fvo) fvo_tot <= fvo_tot + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic cyc(input logic f, input logic l, input logic d, input int data);
        fvi  = f;
        lvi  = l;
        dvi  = d;
        dati = DW'(data);
        if (f) fvi_cnt++;
        @(posedge img_clk);
        #1;
    endtask

    function automatic int pix(input int l, input int p);
        return l * 32 + p;
    endfunction

    // cut_np > 0: last line carries cut_np pixels and fvi falls while lvi is still high.
    // chg_line >= 0: at that line, enable is forced to 1 and col_start to 0.
    task automatic run_frame(input int nl, input int np, input int cut_np, input int chg_line);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int l = 0; l < nl; l++) begin
            if (l == chg_line) begin
                enable    = 1'b1;
                col_start = '0;
            end
            if (cut_np > 0 && l == nl - 1) begin
                for (int p = 0; p < cut_np; p++) cyc(1, 1, 1, pix(l, p));
                cut_lvo_pre = int'(lvo);
                cyc(0, 1, 0, 0);
                cut_lvo_post = int'(lvo);
                cut_dvo_post = int'(dvo);
            end else begin
                for (int p = 0; p < np; p++) cyc(1, 1, 1, pix(l, p));
                cyc(1, 0, 0, 0);
                cyc(1, 0, 0, 0);
            end
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    task automatic check_pixels(input string tag, input int base);
        check({tag, "_count"}, got.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check({tag, "_pix"}, (base + i < got.size()) ? got[base + i] : -1, exp_q[i]);
        end
    endtask

    task automatic set_win(input int cs, input int nc, input int rs, input int nr);
        col_start = NW'(cs);
        num_cols  = NW'(nc);
        row_start = NW'(rs);
        num_rows  = NW'(nr);
    endtask

    initial begin
        int base, d0, l0, f0, fv0;

        reset  = 1'b1;
        enable = 1'b0;
        fvi = 1'b0; lvi = 1'b0; dvi = 1'b0; dati = '0;
        set_win(0, 0, 0, 0);
        repeat (3) @(posedge img_clk);
        #1;
        check("rst_dato", int'(dato), 0);
        check("rst_dvo", int'(dvo), 0);
        check("rst_lvo", int'(lvo), 0);
        check("rst_fvo", int'(fvo), 0);
        check("rst_meas_cols", int'(meas_cols), 0);
        check("rst_meas_rows", int'(meas_rows), 0);
        check("rst_frame_count", int'(frame_count), 0);
        reset = 1'b0;

        // Basic 4x8 frame with a 3x2 window
        enable = 1'b1;
        set_win(2, 3, 1, 2);
        base = got.size(); l0 = lvo_tot; f0 = fvo_tot; fv0 = fvi_cnt;
        run_frame(4, 8, 0, -1);
        exp_q = {34, 35, 36, 66, 67, 68};
        check_pixels("basic", base);
        check("basic_lvo_cycles", lvo_tot - l0, 16);
        check("basic_fvo_cycles", fvo_tot - f0, fvi_cnt - fv0);
        check("basic_meas_cols", int'(meas_cols), 8);
        check("basic_meas_rows", int'(meas_rows), 4);
        check("basic_frame_count", int'(frame_count), 1);

        // Window running past the line end, start+size needs the extra bit
        set_win(6, 10, 0, 2);
        base = got.size();
        run_frame(2, 8, 0, -1);
        exp_q = {6, 7, 38, 39};
        check_pixels("trunc", base);
        check("trunc_frame_count", int'(frame_count), 2);

        // enable low at frame start, raised mid-frame
        enable = 1'b0;
        set_win(2, 3, 1, 2);
        d0 = dvo_tot; l0 = lvo_tot; f0 = fvo_tot;
        run_frame(4, 8, 0, 1);
        check("dis_dvo", dvo_tot - d0, 0);
        check("dis_lvo", lvo_tot - l0, 0);
        check("dis_fvo", fvo_tot - f0, 0);
        // next frame: enabled, col_start changed mid-frame must be ignored
        enable = 1'b1;
        col_start = NW'(2);
        base = got.size();
        run_frame(4, 8, 0, 2);
        exp_q = {34, 35, 36, 66, 67, 68};
        check_pixels("reen", base);
        check("reen_frame_count", int'(frame_count), 4);

        // num_cols = 0: nothing but fvo
        set_win(0, 0, 0, 4);
        d0 = dvo_tot; l0 = lvo_tot; f0 = fvo_tot; fv0 = fvi_cnt;
        run_frame(2, 8, 0, -1);
        check("zero_dvo", dvo_tot - d0, 0);
        check("zero_lvo", lvo_tot - l0, 0);
        check("zero_fvo", fvo_tot - f0, fvi_cnt - fv0);

        // fvi falls with lvi high
        set_win(0, 8, 0, 4);
        d0 = dvo_tot;
        run_frame(3, 8, 5, -1);
        check("cut_lvo_pre", cut_lvo_pre, 1);
        check("cut_lvo_post", cut_lvo_post, 0);
        check("cut_dvo_post", cut_dvo_post, 0);
        check("cut_dvo_total", dvo_tot - d0, 21);
        check("cut_meas_cols", int'(meas_cols), 8);
        check("cut_meas_rows", int'(meas_rows), 2);
        check("cut_frame_count", int'(frame_count), 6);

        // Reset asserted mid-frame, released with fvi high
        set_win(2, 3, 1, 2);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int p = 0; p < 8; p++) cyc(1, 1, 1, pix(0, p));
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int p = 0; p < 3; p++) cyc(1, 1, 1, pix(1, p));
        check("mid_pre_dvo", int'(dvo), 1);
        reset = 1'b1;
        cyc(1, 1, 1, pix(1, 3));
        check("mid_rst_dvo", int'(dvo), 0);
        check("mid_rst_lvo", int'(lvo), 0);
        check("mid_rst_fvo", int'(fvo), 0);
        check("mid_rst_meas_cols", int'(meas_cols), 0);
        check("mid_rst_frame_count", int'(frame_count), 0);
        reset = 1'b0;
        d0 = dvo_tot; l0 = lvo_tot; f0 = fvo_tot;
        for (int p = 4; p < 8; p++) cyc(1, 1, 1, pix(1, p));
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int l = 2; l < 4; l++) begin
            for (int p = 0; p < 8; p++) cyc(1, 1, 1, pix(l, p));
            cyc(1, 0, 0, 0);
            cyc(1, 0, 0, 0);
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("mid_sup_dvo", dvo_tot - d0, 0);
        check("mid_sup_lvo", lvo_tot - l0, 0);
        check("mid_sup_fvo", fvo_tot - f0, 0);
        check("mid_sup_frame_count", int'(frame_count), 0);
        check("mid_sup_meas_rows", int'(meas_rows), 0);
        base = got.size();
        run_frame(4, 8, 0, -1);
        exp_q = {34, 35, 36, 66, 67, 68};
        check_pixels("mid_next", base);
        check("mid_next_frame_count", int'(frame_count), 1);

        // frame_count wrap at 2^NW and column counter saturation
        set_win(0, 0, 0, 0);
        for (int i = 0; i < 14; i++) run_frame(1, 2, 0, -1);
        check("wrap_pre_frame_count", int'(frame_count), 15);
        run_frame(1, 20, 0, -1);
        check("wrap_frame_count", int'(frame_count), 0);
        check("sat_meas_cols", int'(meas_cols), 15);
        check("sat_meas_rows", int'(meas_rows), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mipi_img_window.md
MIPI_IMG_WINDOW -- requirements
Module: mipi_img_window

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, pixel width; matches deserializer dato.
REQ-002 SHALL have parameter DIM_WIDTH, default 16, width of all row/column/count quantities.
REQ-003 img_clk  input  1  sole clock, same domain as deserializer img_clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  window pass-through enable; sampled only at frame start.
REQ-006 dati  input  DATA_WIDTH  pixel data from deserializer.
REQ-007 dvi / lvi / fvi  input  1 each  pixel valid, line valid, frame valid from deserializer.
REQ-008 col_start, num_cols, row_start, num_rows  input  DIM_WIDTH each  crop window; zero-based offsets, sizes in pixels and lines.
REQ-009 dato  output  DATA_WIDTH  cropped pixel.
REQ-010 dvo / lvo / fvo  output  1 each  cropped pixel valid, line valid, frame valid.
REQ-011 meas_cols  output  DIM_WIDTH  dvi count of the last completed input line.
REQ-012 meas_rows  output  DIM_WIDTH  line count of the last completed input frame.
REQ-013 frame_count  output  DIM_WIDTH  completed input frames since reset.

Function
REQ-014 Edge detection SHALL use 1-cycle registered copies of fvi and lvi; frame start = fvi rise, frame end = fvi fall, line start = lvi rise while frame active, line end = lvi fall while frame active.
REQ-015 After reset, block SHALL be DISARMED; it SHALL enter ARMED only after sampling fvi=0, so a frame in progress at reset release produces no output and no measurement.
REQ-016 States: DISARMED -> ARMED (fvi=0), ARMED -> FRAME (frame start), FRAME -> ARMED (frame end); reset forces DISARMED from any state.
REQ-017 On frame start, block SHALL latch enable, col_start, num_cols, row_start, num_rows; mid-frame changes SHALL have no effect until the next frame start.
REQ-018 Row counter SHALL clear at frame start and increment at each line end; column counter SHALL clear at line start and increment on each dvi while lvi=1.
REQ-019 Pixel is in window iff latched enable=1, row_start <= row < row_start+num_rows, col_start <= col < col_start+num_cols; comparisons SHALL use DIM_WIDTH+1-bit sums (no wrap).
REQ-020 dvo SHALL be 1 exactly one cycle after an in-window dvi, with dato = that dati; dato SHALL hold its last value when dvo=0.
REQ-021 lvo SHALL be registered lvi AND (current row in window) AND latched enable; latency 1 cycle.
REQ-022 fvo SHALL be registered fvi AND state FRAME AND latched enable; latency 1 cycle.
REQ-023 num_cols=0 or num_rows=0 SHALL yield no dvo/lvo for the frame; fvo still follows fvi.
REQ-024 Window beyond line or frame extent SHALL be truncated; no padding pixels generated.
REQ-025 dvi while lvi=0, or lvi/dvi while state not FRAME, SHALL be ignored and not counted.
REQ-026 At line end, meas_cols SHALL load the column counter in the same cycle the registered lvi falls.
REQ-027 At frame end, meas_rows SHALL load the row counter and frame_count SHALL increment, wrapping from all-ones to 0.
REQ-028 Row and column counters SHALL saturate at all-ones rather than wrap.
REQ-029 Frame end with lvi still high SHALL terminate the line: lvo and dvo drop on the next cycle, meas_cols not updated for that line.

Reset
REQ-030 While reset=1 on a clock edge: dato=0, dvo=0, lvo=0, fvo=0, meas_cols=0, meas_rows=0, frame_count=0, all counters 0, latched enable 0, state DISARMED.
REQ-031 Reset asserted mid-frame SHALL drop dvo/lvo/fvo on the next edge and suppress the remainder of that frame per REQ-015.

Verification
REQ-032 Frame of 4 lines x 8 pixels, window col_start=2,num_cols=3,row_start=1,num_rows=2 -> exactly 6 dvo pulses carrying pixels (1,2..4),(2,2..4); meas_cols=8, meas_rows=4, frame_count=1.
REQ-033 enable=0 at frame start, toggled to 1 mid-frame -> fvo/lvo/dvo stay 0 all frame; next frame with enable=1 passes window.
REQ-034 Reset released with fvi=1 mid-frame -> no outputs, frame_count stays 0 until one full subsequent frame, then 1.
REQ-035 Window col_start=6,num_cols=10 on 8-pixel lines -> 2 dvo per windowed line (cols 6,7), no extra pulses.
REQ-036 fvi falls while lvi=1 -> lvo, dvo 0 next cycle, meas_rows updated, meas_cols retains prior line value.
REQ-037 frame_count preset by running 2^DIM_WIDTH frames (DIM_WIDTH=4 build, 16 frames) -> wraps to 0.
